// File: rtl/apb_pkg.sv
// apb_pkg: shared types and default configuration for the APB master bridge.
//   apb_state_t        - bridge FSM state encoding (IDLE / SETUP / ACCESS)
//   APB_ADDR_W         - default APB address width
//   APB_DATA_W         - default APB data width
//   APB_TIMEOUT_CYCLES - default ACCESS-phase watchdog limit
package apb_pkg;

  localparam int unsigned APB_ADDR_W         = 16;
  localparam int unsigned APB_DATA_W         = 32;
  localparam int unsigned APB_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

endpackage

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns a valid/ready command port into single APB
// transfers and reports each completion as a one-cycle response pulse.
//
// Optional build macro: APB_TIMEOUT_EN compiles in an ACCESS-phase watchdog
// that aborts a transfer after TIMEOUT_CYCLES cycles and flags rsp_err.
//
// Ports:
//   pclk, preset          clock, synchronous active-high reset
//   req_valid/req_ready   command handshake (req_ready is combinational)
//   req_write/addr/wdata  command payload
//   rsp_valid             one-cycle completion pulse, no back-pressure
//   rsp_rdata             read data (0 for writes/timeouts), held until next completion
//   rsp_err               completion was a watchdog timeout
//   psel/penable/pwrite   APB control
//   paddr/pwdata          APB address and write data
//   pready/prdata         APB slave response, sampled only in ACCESS
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = APB_ADDR_W,
  parameter int unsigned DATA_W         = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic [DATA_W-1:0] prdata
);

  apb_state_t        state, state_nxt;
  logic              psel_nxt, penable_nxt, pwrite_nxt, rsp_valid_nxt;
  logic [ADDR_W-1:0] paddr_nxt;
  logic [DATA_W-1:0] pwdata_nxt, rsp_rdata_nxt;

`ifdef APB_TIMEOUT_EN
  // Counter must hold TIMEOUT_CYCLES-1 and one increment past it.
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt, wd_cnt_nxt;
  logic             rsp_err_q, rsp_err_nxt;
  logic             wd_expired;

  assign wd_expired = (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err    = rsp_err_q;
`else
  // Watchdog compiled out; keep the parameter referenced.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^32'(TIMEOUT_CYCLES);
  assign rsp_err            = 1'b0;
`endif

  // Only IDLE can take a command, and never while reset is held.
  assign req_ready = (state == IDLE) && !preset;

  // Next-state and next-output computation.
  always_comb begin
    state_nxt     = state;
    psel_nxt      = psel;
    penable_nxt   = penable;
    pwrite_nxt    = pwrite;
    paddr_nxt     = paddr;
    pwdata_nxt    = pwdata;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
`ifdef APB_TIMEOUT_EN
    wd_cnt_nxt    = wd_cnt;
    rsp_err_nxt   = rsp_err_q;
`endif

    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          state_nxt   = SETUP;
          psel_nxt    = 1'b1;
          penable_nxt = 1'b0;
          pwrite_nxt  = req_write;
          paddr_nxt   = req_addr;
          pwdata_nxt  = req_wdata;
        end
      end

      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
`ifdef APB_TIMEOUT_EN
        wd_cnt_nxt  = '0;
`endif
      end

      ACCESS: begin
        // A slave completing on the expiry edge wins over the timeout.
        if (pready) begin
          state_nxt     = IDLE;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = pwrite ? '0 : prdata;
`ifdef APB_TIMEOUT_EN
          rsp_err_nxt   = 1'b0;
`endif
        end
`ifdef APB_TIMEOUT_EN
        else if (wd_expired) begin
          state_nxt     = IDLE;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_rdata_nxt = '0;
          rsp_err_nxt   = 1'b1;
        end else begin
          wd_cnt_nxt    = wd_cnt + CNT_W'(1);
        end
`endif
      end

      default: begin
        state_nxt   = IDLE;
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      psel      <= psel_nxt;
      penable   <= penable_nxt;
      pwrite    <= pwrite_nxt;
      paddr     <= paddr_nxt;
      pwdata    <= pwdata_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

`ifdef APB_TIMEOUT_EN
  // Watchdog count and error flag.
  always_ff @(posedge pclk) begin
    if (preset) begin
      wd_cnt    <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wd_cnt    <= wd_cnt_nxt;
      rsp_err_q <= rsp_err_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_apb_master_bridge.sv
// Scoreboard bench for apb_master_bridge: the driver queues expected APB
// commands, a slave model queues expected responses, and a monitor checks
// every rsp_valid pulse against the queue.
module tb_apb_master_bridge;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          pclk, preset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          psel, penable, pwrite, pready;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pready(pready), .prdata(prdata)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] sdata;  // data the slave returns for a read
    int            waits;  // slave wait states before pready
    int            acc;    // cycle count at the acceptance edge
  } cmd_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            cyc;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_psel"},      64'(psel),      64'(0));
    check({tag, "_penable"},   64'(penable),   64'(0));
    check({tag, "_pwrite"},    64'(pwrite),    64'(0));
    check({tag, "_paddr"},     64'(paddr),     64'(0));
    check({tag, "_pwdata"},    64'(pwdata),    64'(0));
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
    check({tag, "_rsp_err"},   64'(rsp_err),   64'(0));
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
  endtask

  // Present a command and hold it until accepted; returns the acceptance cycle.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] sd, input int w, output int acc);
    cmd_t c;
    bit   ok;
    ok = 1'b0;
    @(negedge pclk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    for (int t = 0; t < 200; t++) begin
      #1;
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge pclk);
    end
    check("accept_in_budget", 64'(ok), 64'(1));
    acc     = cyc + 1;
    c.wr    = wr;
    c.addr  = a;
    c.wdata = d;
    c.sdata = sd;
    c.waits = w;
    c.acc   = acc;
    if (ok) begin
      cmd_q.push_back(c);
      @(posedge pclk);
    end
  endtask

  // Drop req_valid and scramble the payload, which must not be latched.
  task automatic idle();
    @(negedge pclk);
    req_valid = 1'b0;
    req_write = 1'($urandom_range(0, 1));
    req_addr  = AW'($urandom);
    req_wdata = $urandom;
  endtask

  // APB slave model and bus-side checks.
  initial begin : slave
    cmd_t cur;
    bit   in_xfer, cur_err;
    int   acc_cnt, psel_cnt;
    rsp_t r;
    in_xfer  = 1'b0;
    cur_err  = 1'b0;
    acc_cnt  = 0;
    psel_cnt = 0;
    pready   = 1'b0;
    prdata   = '0;
    cur      = '{wr: 1'b0, addr: '0, wdata: '0, sdata: '0, waits: 0, acc: 0};
    forever begin
      @(negedge pclk);
      if (psel && !penable) begin
        check("setup_once", 64'(in_xfer), 64'(0));
        check("setup_has_cmd", 64'(cmd_q.size() != 0), 64'(1));
        if (cmd_q.size() != 0) cur = cmd_q.pop_front();
        check("setup_paddr",  64'(paddr),  64'(cur.addr));
        check("setup_pwrite", 64'(pwrite), 64'(cur.wr));
        check("setup_pwdata", 64'(pwdata), 64'(cur.wdata));
        in_xfer  = 1'b1;
        acc_cnt  = 0;
        psel_cnt = 1;
        cur_err  = TO_EN && (cur.waits >= int'(TO));
        r.err    = cur_err;
        r.rdata  = (cur_err || cur.wr) ? '0 : cur.sdata;
        r.cyc    = cur.acc + 2 + (cur_err ? int'(TO) - 1 : cur.waits);
        rsp_q.push_back(r);
        pready   = 1'($urandom_range(0, 1));
        prdata   = $urandom;
      end else if (psel && penable) begin
        check("access_after_setup", 64'(in_xfer), 64'(1));
        acc_cnt++;
        psel_cnt++;
        check("access_paddr_stable",  64'(paddr),  64'(cur.addr));
        check("access_pwrite_stable", 64'(pwrite), 64'(cur.wr));
        check("access_pwdata_stable", 64'(pwdata), 64'(cur.wdata));
        if (acc_cnt == cur.waits + 1) begin
          pready = 1'b1;
          prdata = cur.sdata;
        end else begin
          pready = 1'b0;
          prdata = $urandom;
        end
      end else begin
        if (in_xfer && !preset)
          check("psel_cycles", 64'(psel_cnt),
                64'(1 + (cur_err ? int'(TO) : cur.waits + 1)));
        in_xfer = 1'b0;
        pready  = 1'($urandom_range(0, 1));
        prdata  = $urandom;
      end
    end
  end

  // Response monitor: every pulse must match the oldest expected response.
  initial begin : rsp_mon
    rsp_t e;
    forever begin
      @(negedge pclk);
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          check("rsp_expected", 64'(rsp_q.size()), 64'(1));
        end else begin
          e = rsp_q.pop_front();
          check("rsp_rdata",   64'(rsp_rdata), 64'(e.rdata));
          check("rsp_err",     64'(rsp_err),   64'(e.err));
          check("rsp_latency", 64'(cyc),       64'(e.cyc));
          check("rsp_psel_low",    64'(psel),    64'(0));
          check("rsp_penable_low", 64'(penable), 64'(0));
        end
      end
    end
  end

  initial begin : driver
    int  acc, acc2, w, gap;
    bit  seen;
    preset    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge pclk);
    #1 check_all_zero("reset");
    @(negedge pclk);
    preset = 1'b0;

    // Zero-wait write.
    issue(1'b1, 16'h0010, 32'hDEADBEEF, 32'h0, 0, acc);
    idle();
    // Read with three wait states.
    issue(1'b0, 16'h0024, 32'h0, 32'h12345678, 3, acc);
    idle();
    // Two reads with req_valid held: three cycles apart.
    issue(1'b0, 16'h0040, 32'h0, 32'hA5A5_0001, 0, acc);
    issue(1'b0, 16'h0044, 32'h0, 32'hA5A5_0002, 0, acc2);
    check("b2b_spacing", 64'(acc2 - acc), 64'(3));
    idle();

    // Reset in the second ACCESS cycle aborts the transfer.
    issue(1'b1, 16'h0100, 32'hCAFE_0001, 32'h0, 5, acc);
    idle();
    seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge pclk);
      if (psel && penable) begin
        seen = 1'b1;
        break;
      end
    end
    check("reach_access", 64'(seen), 64'(1));
    @(negedge pclk);
    preset = 1'b1;
    rsp_q.delete();
    @(negedge pclk);
    #1 check_all_zero("abort");
    @(negedge pclk);
    preset = 1'b0;
    issue(1'b0, 16'h0200, 32'h0, 32'h0BAD_F00D, 1, acc);
    idle();

`ifdef APB_TIMEOUT_EN
    // Slave never responds: watchdog completion with error.
    issue(1'b0, 16'h0300, 32'h0, 32'h1111_2222, 100, acc);
    idle();
    // Slave responds in the last permitted ACCESS cycle: normal completion.
    issue(1'b0, 16'h0304, 32'h0, 32'h3333_4444, int'(TO) - 1, acc);
    idle();
    issue(1'b1, 16'h0308, 32'h5555_6666, 32'h0, 100, acc);
    idle();
`endif

    // Randomized traffic, mixing idle gaps and back-to-back commands.
    for (int i = 0; i < 40; i++) begin
      w = int'($urandom_range(0, 4));
      issue(1'($urandom_range(0, 1)), AW'($urandom), $urandom, $urandom, w, acc);
      gap = int'($urandom_range(0, 3));
      if (gap > 0) begin
        idle();
        repeat (gap - 1) @(negedge pclk);
      end
    end

    idle();
    for (int t = 0; t < 200; t++) begin
      if (rsp_q.size() == 0 && cmd_q.size() == 0 && !psel) break;
      @(negedge pclk);
    end
    repeat (3) @(negedge pclk);
    check("drain_rsp_q", 64'(rsp_q.size()), 64'(0));
    check("drain_cmd_q", 64'(cmd_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : global_timeout
    #200000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, the APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, the APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 64, the ACCESS-phase watchdog limit; it is used only when APB_TIMEOUT_EN is defined.
REQ-004 SHALL have ports, clock and reset first:
 pclk  in  1  sole clock; all logic on rising edge.
 preset  in  1  synchronous, active-high reset.
 req_valid  in  1  command request.
 req_ready  out  1  bridge can accept a command.
 req_write  in  1  1=write, 0=read.
 req_addr  in  ADDR_W  target address.
 req_wdata  in  DATA_W  write data.
 rsp_valid  out  1  one-cycle completion pulse.
 rsp_rdata  out  DATA_W  read data.
 rsp_err  out  1  transfer timed out.
 psel  out  1  APB select.
 penable  out  1  APB enable.
 pwrite  out  1  APB direction.
 paddr  out  ADDR_W  APB address.
 pwdata  out  DATA_W  APB write data.
 pready  in  1  APB ready from the slave.
 prdata  in  DATA_W  APB read data from the slave.

Function
REQ-005 SHALL implement FSM states IDLE, SETUP and ACCESS; all outputs SHALL be registered except req_ready.
REQ-006 SHALL drive req_ready = (state==IDLE) combinationally; a command is accepted on an edge where req_valid && req_ready.
REQ-007 On acceptance, SHALL latch req_write/addr/wdata onto pwrite/paddr/pwdata and go to SETUP: psel=1, penable=0 for exactly one cycle.
REQ-008 From SETUP, SHALL go unconditionally to ACCESS: psel=1, penable=1; paddr/pwrite/pwdata SHALL hold stable through SETUP and ACCESS.
REQ-009 In ACCESS, SHALL stay while pready=0 (unbounded wait states unless REQ-021 applies).
REQ-010 On an edge in ACCESS with pready=1: SHALL return to IDLE, clear psel and penable, and pulse rsp_valid for one cycle with rsp_err=0.
REQ-011 SHALL capture rsp_rdata from prdata at completion for reads; SHALL set rsp_rdata=0 for writes; rsp_rdata SHALL hold until the next completion.
REQ-012 Minimum latency: acceptance edge N, SETUP cycle N..N+1, ACCESS N+1..N+2, rsp_valid high in cycle N+2..N+3 when pready=1 immediately; back-to-back throughput SHALL be one transfer per 3 cycles.
REQ-013 req_ready SHALL be high in the rsp_valid cycle, so the next command can be accepted on that edge.
REQ-014 rsp has no back-pressure; the consumer SHALL always accept rsp_valid.
REQ-015 pready and prdata SHALL be ignored outside ACCESS.
REQ-016 paddr/pwdata/pwrite SHALL retain their last values while in IDLE; they are don't-care to the slave.

Reset
REQ-017 When preset=1 at an edge: state=IDLE; psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata and rsp_err SHALL all be 0; the watchdog count SHALL be 0.
REQ-018 Reset during SETUP or ACCESS SHALL abort the transfer: psel drops on that edge and no rsp_valid is produced.
REQ-019 While preset=1, req_ready SHALL be 0.

Configuration
REQ-020 Macro APB_TIMEOUT_EN SHALL compile the watchdog in or out.
REQ-021 With APB_TIMEOUT_EN defined: a counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready=0. When it reaches TIMEOUT_CYCLES-1 with pready still 0, the bridge SHALL return to IDLE, drop psel/penable, and pulse rsp_valid with rsp_err=1 and rsp_rdata=0. If pready=1 on the same edge, normal completion (REQ-010) SHALL take priority.
REQ-022 Without APB_TIMEOUT_EN: no counter logic; rsp_err SHALL be tied to 0.

Structure
REQ-023 Package apb_pkg SHALL hold the state enum (IDLE/SETUP/ACCESS) and the default width and timeout localparams.
REQ-024 The design SHALL be a single module with no sub-modules; the watchdog lives inside an `ifdef APB_TIMEOUT_EN region.

Verification
REQ-025 Write addr=0x0010, data=0xDEADBEEF, slave pready=1 with no waits -> psel for 2 cycles, penable for 1, rsp_valid 2 cycles after acceptance, rsp_rdata=0.
REQ-026 Read addr=0x0024, slave 3 wait states, prdata=0x12345678 -> ACCESS lasts 4 cycles, rsp_rdata=0x12345678, and paddr is stable throughout.
REQ-027 Two reads with req_valid held high -> second acceptance on the first rsp_valid edge; transfers start 3 cycles apart.
REQ-028 preset asserted in the 2nd ACCESS cycle -> all outputs 0 on the next edge and no rsp_valid; a new command after reset completes normally.
REQ-029 APB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and pready held 0 -> rsp_valid with rsp_err=1 after 8 ACCESS cycles; psel=0 on the following cycle.
REQ-030 APB_TIMEOUT_EN with pready rising exactly in the 8th ACCESS cycle -> normal completion, rsp_err=0.
